// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1+ frames, LSB first, paced by an external
// oversample tick. Emits one-cycle valid / framing-error strobes per frame.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx_pin,
  output logic [7:0] rxdata,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rxdata_q, rxdata_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_frame_err_q, rx_frame_err_d;
  logic            rx_meta_q, rx_s_q;

  // Two-flop synchronizer, idle-high so reset never looks like a start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_pin;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      rxdata_q       <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      rxdata_q       <= rxdata_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    rxdata_d       = rxdata_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;
    if (en) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == HALF_M1) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            // A start bit that is high again at its center was noise
            state_d   = rx_s_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == FULL_M1) begin
            cnt_d     = '0;
            shift_d   = {rx_s_q, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = S_STOP;
          end
        end
        S_STOP: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == FULL_M1) begin
            cnt_d = '0;
            if (rx_s_q) begin
              rxdata_d   = shift_q;
              rx_valid_d = 1'b1;
              state_d    = S_IDLE;
            end else begin
              rx_frame_err_d = 1'b1;
              state_d        = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          // Wait out a held-low line so it yields a single error
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rxdata       = rxdata_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: OVERSAMPLE=16, en every 4 clk (64 clk per bit),
// serial frames driven by a bench-side transmitter task.
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       rx_pin = 1'b1;
  logic [7:0] rxdata;
  logic       rx_valid, rx_frame_err, rx_busy;

  int errs = 0;
  int checks = 0;

  logic [1:0] ediv = '0;
  int         vcnt = 0;
  int         fcnt = 0;
  int         both_cnt = 0;
  logic [7:0] got [0:15];

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .en(en), .rx_pin(rx_pin),
    .rxdata(rxdata), .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ediv <= ediv + 2'd1;
    en   <= (ediv == 2'd3);
  end

  always @(negedge clk) begin
    if (rx_valid) begin
      got[vcnt[3:0]] <= rxdata;
      vcnt <= vcnt + 1;
    end
    if (rx_frame_err) fcnt <= fcnt + 1;
    if (rx_valid && rx_frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int nclk);
    rx_pin = lvl;
    repeat (nclk) @(negedge clk);
  endtask

  // start, 8 data bits LSB first, one stop bit of the given level, extra idle stops
  task automatic send(input logic [7:0] b, input logic stop_lvl, input int extra_stops);
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) hold(b[i], BIT_CLK);
    hold(stop_lvl, BIT_CLK);
    hold(1'b1, extra_stops * BIT_CLK);
  endtask

  int base;

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_rxdata", {24'h0, rxdata}, 32'h00);
    chk("reset_valid", {31'h0, rx_valid}, 32'h0);
    chk("reset_ferr", {31'h0, rx_frame_err}, 32'h0);
    chk("reset_busy", {31'h0, rx_busy}, 32'h0);

    // single byte, 2 stop bits
    hold(1'b0, BIT_CLK);
    chk("single_busy_mid", {31'h0, rx_busy}, 32'h1);
    for (int i = 0; i < 8; i++) hold(logic'((8'h55 >> i) & 8'h1), BIT_CLK);
    hold(1'b1, 2 * BIT_CLK);
    chk("single_vcnt", vcnt, 1);
    chk("single_byte", {24'h0, got[0]}, 32'h55);
    chk("single_ferr", fcnt, 0);
    chk("single_busy_after", {31'h0, rx_busy}, 32'h0);

    // glitch: 16 clk low
    hold(1'b0, 12);
    chk("glitch_busy_high", {31'h0, rx_busy}, 32'h1);
    hold(1'b0, 4);
    hold(1'b1, 40);
    chk("glitch_busy_low", {31'h0, rx_busy}, 32'h0);
    hold(1'b1, BIT_CLK);
    chk("glitch_vcnt", vcnt, 1);
    chk("glitch_ferr", fcnt, 0);

    // framing error then good frame
    send(8'h81, 1'b0, 2);
    chk("frame_ferr", fcnt, 1);
    chk("frame_vcnt", vcnt, 1);
    chk("frame_rxdata_kept", {24'h0, rxdata}, 32'h55);
    send(8'h7E, 1'b1, 1);
    chk("after_ferr_vcnt", vcnt, 2);
    chk("after_ferr_rxdata", {24'h0, rxdata}, 32'h7E);

    // back-to-back stream, uart_tx style 2 stop bits
    base = vcnt;
    send(8'h00, 1'b1, 1);
    send(8'hFF, 1'b1, 1);
    send(8'hA3, 1'b1, 1);
    send(8'h3C, 1'b1, 1);
    chk("b2b_count", vcnt - base, 4);
    chk("b2b_0", {24'h0, got[2]}, 32'h00);
    chk("b2b_1", {24'h0, got[3]}, 32'hFF);
    chk("b2b_2", {24'h0, got[4]}, 32'hA3);
    chk("b2b_3", {24'h0, got[5]}, 32'h3C);

    // break: 30 bit periods low
    hold(1'b0, 30 * BIT_CLK);
    hold(1'b1, 2 * BIT_CLK);
    send(8'h3C, 1'b1, 1);
    chk("break_ferr", fcnt, 2);
    chk("break_vcnt", vcnt, 7);
    chk("break_rxdata", {24'h0, rxdata}, 32'h3C);

    // reset during data bit 4 of 0xC9
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) hold(logic'((8'hC9 >> i) & 8'h1), BIT_CLK);
    hold(1'b0, 32);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx_pin = 1'b1;
    chk("rst_mid_rxdata", {24'h0, rxdata}, 32'h00);
    chk("rst_mid_busy", {31'h0, rx_busy}, 32'h0);
    chk("rst_mid_valid", {31'h0, rx_valid}, 32'h0);
    chk("rst_mid_ferr", {31'h0, rx_frame_err}, 32'h0);
    hold(1'b1, 2 * BIT_CLK);
    chk("rst_mid_no_strobe", vcnt + fcnt, 9);
    send(8'h12, 1'b1, 1);
    chk("post_rst_vcnt", vcnt, 8);
    chk("post_rst_rxdata", {24'h0, rxdata}, 32'h12);
    chk("never_both", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
